// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the data-memory port arbiter, its two requesters and the memory.
// master = arbiter side, slave = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic              interlock;

  logic              core_req;
  logic [ADDR_W-1:0] core_addr;
  logic [BE_W-1:0]   core_wea;
  logic [DATA_W-1:0] core_dina;
  logic              core_stall;

  logic              dma_valid;
  logic              dma_ready;
  logic [ADDR_W-1:0] dma_addr;
  logic [BE_W-1:0]   dma_wea;
  logic [DATA_W-1:0] dma_dina;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_used;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_wea;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_doutb;

  modport master (
    input  interlock,
    input  core_req, core_addr, core_wea, core_dina,
    output core_stall,
    input  dma_valid, dma_addr, dma_wea, dma_dina,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_used, mem_addr, mem_wea, mem_dina,
    input  mem_doutb
  );

  modport slave (
    output interlock,
    output core_req, core_addr, core_wea, core_dina,
    input  core_stall,
    output dma_valid, dma_addr, dma_wea, dma_dina,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_used, mem_addr, mem_wea, mem_dina,
    output mem_doutb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority, a starvation guard forces a DMA grant,
// and DMA reads are tracked through the memory's fixed read latency.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  localparam int BE_W = DATA_W / 8;

  localparam logic [0:0] CORE_PRI  = 1'b0;
  localparam logic [0:0] FORCE_DMA = 1'b1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [7:0]        starve_cnt_r;
  logic [7:0]        starve_nxt_s;
  logic [RD_LAT-1:0] rd_pipe_r;
  logic [RD_LAT-1:0] rd_pipe_nxt_s;
  logic              core_gnt_s;
  logic              dma_gnt_s;
  logic              dma_rd_s;
  logic              rvalid_s;

  // Grant decision; nothing is granted while in reset or while the pipeline is frozen.
  always_comb begin
    core_gnt_s = 1'b0;
    dma_gnt_s  = 1'b0;
    if (rst || bus.interlock) begin
      core_gnt_s = 1'b0;
      dma_gnt_s  = 1'b0;
    end else begin
      core_gnt_s = bus.core_req && ((state_r == CORE_PRI) || !bus.dma_valid);
      dma_gnt_s  = bus.dma_valid && (!bus.core_req || (state_r == FORCE_DMA));
    end
  end

  // Memory request mux; the idle port presents core address/data with no write enables.
  always_comb begin
    bus.mem_addr = bus.core_addr;
    bus.mem_dina = bus.core_dina;
    bus.mem_wea  = {BE_W{1'b0}};
    if (dma_gnt_s) begin
      bus.mem_addr = bus.dma_addr;
      bus.mem_dina = bus.dma_dina;
      bus.mem_wea  = bus.dma_wea;
    end else if (core_gnt_s) begin
      bus.mem_wea  = bus.core_wea;
    end else begin
      bus.mem_wea  = {BE_W{1'b0}};
    end
  end

  assign bus.mem_used   = core_gnt_s | dma_gnt_s;
  assign bus.dma_ready  = dma_gnt_s;
  assign bus.core_stall = bus.core_req & ~core_gnt_s & ~rst;

  assign dma_rd_s      = dma_gnt_s & (bus.dma_wea == {BE_W{1'b0}});
  assign rd_pipe_nxt_s = (rd_pipe_r << 1) | RD_LAT'(dma_rd_s);

  // Starvation counter and arbitration state for the next cycle.
  always_comb begin
    starve_nxt_s = 8'd0;
    state_nxt_s  = state_r;
    if (bus.dma_valid && !dma_gnt_s) begin
      starve_nxt_s = (starve_cnt_r >= STARVE_LIM) ? STARVE_LIM : (starve_cnt_r + 8'd1);
    end else begin
      starve_nxt_s = 8'd0;
    end
    // FORCE_DMA always grants a waiting DMA, so it lasts exactly one advancing cycle.
    case (state_r)
      CORE_PRI:  state_nxt_s = (starve_nxt_s == STARVE_LIM) ? FORCE_DMA : CORE_PRI;
      FORCE_DMA: state_nxt_s = CORE_PRI;
      default:   state_nxt_s = CORE_PRI;
    endcase
  end

  // State, counter and read-return pipe; all hold while interlock is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= CORE_PRI;
      starve_cnt_r <= 8'd0;
      rd_pipe_r    <= {RD_LAT{1'b0}};
    end else if (!bus.interlock) begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      rd_pipe_r    <= rd_pipe_nxt_s;
    end else begin
      state_r      <= state_r;
      starve_cnt_r <= starve_cnt_r;
      rd_pipe_r    <= rd_pipe_r;
    end
  end

  assign rvalid_s       = rd_pipe_r[RD_LAT-1] & ~bus.interlock;
  assign bus.dma_rvalid = rvalid_s;
  assign bus.dma_rdata  = rvalid_s ? bus.mem_doutb : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 3-cycle-latency memory model.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus8 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus4 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .RD_LAT(3), .STARVE_MAX(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .RD_LAT(3), .STARVE_MAX(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled writes, reads return 3 advancing cycles later, frozen by interlock.
  logic [63:0] mem_arr [0:1023];
  logic [63:0] rp0, rp1, rp2;
  always @(posedge clk) begin
    if (!bus8.interlock) begin
      if (bus8.mem_used) begin
        for (int b = 0; b < 8; b++) begin
          if (bus8.mem_wea[b]) mem_arr[bus8.mem_addr[9:0]][b*8 +: 8] <= bus8.mem_dina[b*8 +: 8];
        end
      end
      rp0 <= (bus8.mem_used && bus8.mem_wea == 8'h00) ? mem_arr[bus8.mem_addr[9:0]] : 64'h0;
      rp1 <= rp0;
      rp2 <= rp1;
    end
  end
  assign bus8.mem_doutb = rp2;
  assign bus4.mem_doutb = 64'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle8();
    bus8.interlock = 1'b0;
    bus8.core_req  = 1'b0;
    bus8.core_addr = 32'h0;
    bus8.core_wea  = 8'h00;
    bus8.core_dina = 64'h0;
    bus8.dma_valid = 1'b0;
    bus8.dma_addr  = 32'h0;
    bus8.dma_wea   = 8'h00;
    bus8.dma_dina  = 64'h0;
  endtask

  task automatic idle4();
    bus4.interlock = 1'b0;
    bus4.core_req  = 1'b0;
    bus4.core_addr = 32'h0;
    bus4.core_wea  = 8'h00;
    bus4.core_dina = 64'h0;
    bus4.dma_valid = 1'b0;
    bus4.dma_addr  = 32'h0;
    bus4.dma_wea   = 8'h00;
    bus4.dma_dina  = 64'h0;
  endtask

  task automatic dma_drive(input logic [31:0] a, input logic [7:0] we, input logic [63:0] d);
    idle8();
    bus8.dma_valid = 1'b1;
    bus8.dma_addr  = a;
    bus8.dma_wea   = we;
    bus8.dma_dina  = d;
  endtask

  // One DMA read with nothing else in flight; return expected exactly 3 cycles later.
  task automatic dma_read_check(input logic [31:0] a, input logic [63:0] exp);
    @(negedge clk);
    dma_drive(a, 8'h00, 64'h0);
    #1;
    check("rd_ready", bus8.dma_ready, 1'b1);
    check("rd_wea", bus8.mem_wea, 8'h00);
    check("rd_addr", bus8.mem_addr, a);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      idle8();
      #1;
      check("rd_early", bus8.dma_rvalid, 1'b0);
    end
    @(negedge clk);
    idle8();
    #1;
    check("rd_rvalid", bus8.dma_rvalid, 1'b1);
    check("rd_rdata", bus8.dma_rdata, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle8();
    idle4();
    bus8.core_req  = 1'b1;
    bus8.dma_valid = 1'b1;

    // Reset: grants forced off even with both requesters active.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_used", bus8.mem_used, 1'b0);
    check("rst_mem_wea", bus8.mem_wea, 8'h00);
    check("rst_dma_ready", bus8.dma_ready, 1'b0);
    check("rst_core_stall", bus8.core_stall, 1'b0);
    check("rst_rvalid", bus8.dma_rvalid, 1'b0);
    check("rst_rdata", bus8.dma_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle8();
    #1;
    check("rst_starve", dut8.starve_cnt_r, 8'd0);

    // Prefill through DMA writes: no return, complete at grant.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] wa;
      logic [63:0] wd;
      wa = (i < 4) ? 32'(i) : 32'h100;
      wd = (i < 4) ? 64'h11 * 64'(i + 1) : 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      dma_drive(wa, 8'hFF, wd);
      #1;
      check("wr_ready", bus8.dma_ready, 1'b1);
      check("wr_used", bus8.mem_used, 1'b1);
      check("wr_wea", bus8.mem_wea, 8'hFF);
      check("wr_dina", bus8.mem_dina, wd);
    end

    // DMA-only read of 0x100.
    dma_read_check(32'h100, 64'h0123_4567_89AB_CDEF);

    // Core write while DMA waits: core wins, starve count becomes 1.
    @(negedge clk);
    dma_drive(32'h5, 8'h00, 64'h0);
    bus8.core_req  = 1'b1;
    bus8.core_addr = 32'h8;
    bus8.core_wea  = 8'hFF;
    bus8.core_dina = 64'h0000_0000_DEAD_BEEF;
    #1;
    check("cw_stall", bus8.core_stall, 1'b0);
    check("cw_dma_ready", bus8.dma_ready, 1'b0);
    check("cw_used", bus8.mem_used, 1'b1);
    check("cw_wea", bus8.mem_wea, 8'hFF);
    check("cw_addr", bus8.mem_addr, 32'h8);
    check("cw_dina", bus8.mem_dina, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk);
    #1;
    check("cw_starve", dut8.starve_cnt_r, 8'd1);
    dma_read_check(32'h8, 64'h0000_0000_DEAD_BEEF);

    // Starvation guard with STARVE_MAX=4: forced DMA grant at cycle 4.
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      bus4.core_req  = 1'b1;
      bus4.core_addr = 32'h40 + 32'(c);
      bus4.dma_valid = (c <= 4) ? 1'b1 : 1'b0;
      bus4.dma_addr  = 32'h200;
      #1;
      check("sv_ready", bus4.dma_ready, (c == 4) ? 1'b1 : 1'b0);
      check("sv_stall", bus4.core_stall, (c == 4) ? 1'b1 : 1'b0);
      check("sv_starve", dut4.starve_cnt_r, (c <= 4) ? 8'(c) : 8'd0);
    end
    @(negedge clk);
    idle4();

    // Interlock for two cycles right after a DMA read grant delays return to t+5.
    @(negedge clk);
    dma_drive(32'h1, 8'h00, 64'h0);
    #1;
    check("il_ready", bus8.dma_ready, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      idle8();
      if (i <= 2) begin
        bus8.interlock = 1'b1;
        bus8.core_req  = 1'b1;
        bus8.dma_valid = 1'b1;
        bus8.dma_addr  = 32'h2;
      end
      #1;
      if (i <= 2) begin
        check("il_used", bus8.mem_used, 1'b0);
        check("il_dma_ready", bus8.dma_ready, 1'b0);
        check("il_stall", bus8.core_stall, 1'b1);
        check("il_wea", bus8.mem_wea, 8'h00);
      end
      check("il_rvalid", bus8.dma_rvalid, (i == 5) ? 1'b1 : 1'b0);
      if (i == 5) check("il_rdata", bus8.dma_rdata, 64'h22);
    end

    // Four back-to-back reads, reset hits at the second return.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dma_drive(32'(i), 8'h00, 64'h0);
      #1;
      check("bb_ready", bus8.dma_ready, 1'b1);
      check("bb_rvalid", bus8.dma_rvalid, (i == 3) ? 1'b1 : 1'b0);
      if (i == 3) check("bb_rdata", bus8.dma_rdata, 64'h11);
    end
    @(negedge clk);
    idle8();
    bus8.core_req  = 1'b1;
    bus8.dma_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("mr_rvalid", bus8.dma_rvalid, 1'b0);
    check("mr_rdata", bus8.dma_rdata, 64'h0);
    check("mr_used", bus8.mem_used, 1'b0);
    check("mr_ready", bus8.dma_ready, 1'b0);
    check("mr_stall", bus8.core_stall, 1'b0);
    check("mr_starve", dut8.starve_cnt_r, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle8();
    #1;
    check("mr_after", bus8.dma_rvalid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("mr_after", bus8.dma_rvalid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
